// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: mode encoding, 32-bit arctangent table and the
// helper that narrows a table entry to a W-bit binary angle.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // round(atan(2^-i) * 2^31 / pi): binary angle where 2^31 is +pi
    localparam logic [31:0] ATAN32 [0:31] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // Narrow ATAN32[i] to a w-bit angle, rounding half up.
    function automatic logic [31:0] atan_w(input int i, input int w);
        logic [32:0] sum;
        logic [32:0] shifted;
        if (w >= 32) begin
            return ATAN32[i[4:0]];
        end
        sum     = {1'b0, ATAN32[i[4:0]]} + (33'd1 << (31 - w));
        shifted = sum >> (32 - w);
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/cordic_pipe_if.sv
// Input/output streams of the CORDIC pipe. The slave view belongs to the
// pipe itself, the master view to whatever produces and consumes samples.
interface cordic_pipe_if #(
    parameter int W = 16
);
    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic signed [W-1:0] in_x;
    logic signed [W-1:0] in_y;
    logic signed [W-1:0] in_z;
    logic                out_valid;
    logic                out_ready;
    logic                out_mode;
    logic signed [W+1:0] out_x;
    logic signed [W+1:0] out_y;
    logic signed [W-1:0] out_z;

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_mode, out_x, out_y, out_z
    );

    modport master (
        output in_valid, in_mode, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_mode, out_x, out_y, out_z
    );
endinterface

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation (index I) with its pipeline registers. The
// direction decision uses this stage's own mode bit so modes can interleave.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int W = 16,
    parameter int I = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_adv,
    input  logic                i_valid,
    input  logic                i_mode,
    input  logic signed [W+1:0] i_x,
    input  logic signed [W+1:0] i_y,
    input  logic signed [W-1:0] i_z,
    output logic                o_valid,
    output logic                o_mode,
    output logic signed [W+1:0] o_x,
    output logic signed [W+1:0] o_y,
    output logic signed [W-1:0] o_z
);
    localparam logic [31:0]         ATAN_FULL = atan_w(I, W);
    localparam logic signed [W-1:0] ATAN_I    = ATAN_FULL[W-1:0];

    logic                w_d_pos;
    logic signed [W+1:0] w_xs, w_ys, w_x, w_y;
    logic signed [W-1:0] w_z;
    logic                r_valid, r_mode;
    logic signed [W+1:0] r_x, r_y;
    logic signed [W-1:0] r_z;

    // d=+1 drives z toward 0 in rotation, y toward 0 in vectoring
    assign w_d_pos = (i_mode == MODE_VEC) ? i_y[W+1] : !i_z[W-1];
    assign w_xs    = i_x >>> I;
    assign w_ys    = i_y >>> I;

    // Micro-rotation datapath; all sums wrap at their declared width
    always_comb begin
        w_x = i_x;
        w_y = i_y;
        w_z = i_z;
        if (w_d_pos) begin
            w_x = i_x - w_ys;
            w_y = i_y + w_xs;
            w_z = i_z - ATAN_I;
        end else begin
            w_x = i_x + w_ys;
            w_y = i_y - w_xs;
            w_z = i_z + ATAN_I;
        end
    end

    // Stage registers move only when the whole pipe advances
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_x     <= w_x;
            r_y     <= w_y;
            r_z     <= w_z;
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;
endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: quadrant pre-rotation, STAGES micro-rotations and
// an output register, all stalled together by a single advance signal.
module cordic_pipe
    import cordic_pkg::*;
#(
    parameter int W      = 16,
    parameter int STAGES = 16
) (
    input logic          clk,
    input logic          rst_n,
    cordic_pipe_if.slave bus
);
    localparam int XW = W + 2;
    localparam logic signed [W-1:0] QUARTER     = {2'b01, {(W-2){1'b0}}};
    localparam logic signed [W-1:0] NEG_QUARTER = {2'b11, {(W-2){1'b0}}};

    logic                 w_adv;
    logic signed [XW-1:0] w_xe, w_ye, w_px, w_py;
    logic signed [W-1:0]  w_pz;

    logic                 r_p_valid, r_p_mode;
    logic signed [XW-1:0] r_p_x, r_p_y;
    logic signed [W-1:0]  r_p_z;

    logic                 w_sv [0:STAGES];
    logic                 w_sm [0:STAGES];
    logic signed [XW-1:0] w_sx [0:STAGES];
    logic signed [XW-1:0] w_sy [0:STAGES];
    logic signed [W-1:0]  w_sz [0:STAGES];

    logic                 r_out_valid, r_out_mode;
    logic signed [XW-1:0] r_out_x, r_out_y;
    logic signed [W-1:0]  r_out_z;

    // An empty or draining output slot lets every register move one step
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_xe = {{2{bus.in_x[W-1]}}, bus.in_x};
    assign w_ye = {{2{bus.in_y[W-1]}}, bus.in_y};

    // Quadrant pre-rotation by +/-pi/2 so the micro-rotations only see
    // angles the CORDIC series can reach
    always_comb begin
        w_px = w_xe;
        w_py = w_ye;
        w_pz = bus.in_z;
        if (bus.in_mode == MODE_ROT) begin
            if (bus.in_z >= QUARTER) begin
                w_px = -w_ye;
                w_py = w_xe;
                w_pz = bus.in_z - QUARTER;
            end else if (bus.in_z < NEG_QUARTER) begin
                w_px = w_ye;
                w_py = -w_xe;
                w_pz = bus.in_z + QUARTER;
            end
        end else if (bus.in_x[W-1]) begin
            if (!bus.in_y[W-1]) begin
                w_px = w_ye;
                w_py = -w_xe;
                w_pz = bus.in_z + QUARTER;
            end else begin
                w_px = -w_ye;
                w_py = w_xe;
                w_pz = bus.in_z - QUARTER;
            end
        end
    end

    // Stage P register; samples offered during reset are dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p_valid <= 1'b0;
            r_p_mode  <= 1'b0;
            r_p_x     <= '0;
            r_p_y     <= '0;
            r_p_z     <= '0;
        end else if (w_adv) begin
            r_p_valid <= bus.in_valid;
            r_p_mode  <= bus.in_mode;
            r_p_x     <= w_px;
            r_p_y     <= w_py;
            r_p_z     <= w_pz;
        end
    end

    assign w_sv[0] = r_p_valid;
    assign w_sm[0] = r_p_mode;
    assign w_sx[0] = r_p_x;
    assign w_sy[0] = r_p_y;
    assign w_sz[0] = r_p_z;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        cordic_stage #(.W(W), .I(gi)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_adv   (w_adv),
            .i_valid (w_sv[gi]),
            .i_mode  (w_sm[gi]),
            .i_x     (w_sx[gi]),
            .i_y     (w_sy[gi]),
            .i_z     (w_sz[gi]),
            .o_valid (w_sv[gi+1]),
            .o_mode  (w_sm[gi+1]),
            .o_x     (w_sx[gi+1]),
            .o_y     (w_sy[gi+1]),
            .o_z     (w_sz[gi+1])
        );
    end

    // Output register holds the result steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_sv[STAGES];
            r_out_mode  <= w_sm[STAGES];
            r_out_x     <= w_sx[STAGES];
            r_out_y     <= w_sy[STAGES];
            r_out_z     <= w_sz[STAGES];
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_mode  = r_out_mode;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.out_z     = r_out_z;
endmodule

// File: tb/tb_cordic_pipe.sv
// Directed bench for cordic_pipe (W=16, STAGES=16): reset state, the four
// reference vectors, a backpressured mixed-mode stream and a mid-stream reset.
module tb_cordic_pipe;
    localparam int W      = 16;
    localparam int STAGES = 16;
    localparam int LAT    = STAGES + 2;

    typedef struct { bit m; int x; int y; int z; } samp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_pipe_if #(.W(W)) bus();

    cordic_pipe #(.W(W), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int atan_tb [0:STAGES-1];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_tol(input string tag, input longint obs, input longint exp,
                             input longint tol);
        n_total++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) n_pass++;
        else $error("FAIL %s: got %0d expected %0d +/-%0d", tag, obs, exp, tol);
    endtask

    function automatic int wx(input int v);
        return (v <<< 14) >>> 14;
    endfunction

    function automatic int wz(input int v);
        return (v <<< 16) >>> 16;
    endfunction

    // Reference CORDIC built from the algorithm description
    function automatic samp_t model(input samp_t s);
        samp_t r;
        int cx, cy, cz, t, dx, dy;
        cx = s.x; cy = s.y; cz = s.z;
        if (!s.m) begin
            if (cz >= 16384) begin
                t = cx; cx = -cy; cy = t; cz = cz - 16384;
            end else if (cz < -16384) begin
                t = cx; cx = cy; cy = -t; cz = cz + 16384;
            end
        end else if (cx < 0) begin
            if (cy >= 0) begin
                t = cx; cx = cy; cy = -t; cz = wz(cz + 16384);
            end else begin
                t = cx; cx = -cy; cy = t; cz = wz(cz - 16384);
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            dx = cy >>> i;
            dy = cx >>> i;
            if (s.m ? (cy < 0) : (cz >= 0)) begin
                cx = wx(cx - dx); cy = wx(cy + dy); cz = wz(cz - atan_tb[i]);
            end else begin
                cx = wx(cx + dx); cy = wx(cy - dy); cz = wz(cz + atan_tb[i]);
            end
        end
        r.m = s.m; r.x = cx; r.y = cy; r.z = cz;
        return r;
    endfunction

    task automatic drive_in(input bit v, input samp_t s);
        bus.in_valid = v;
        bus.in_mode  = s.m;
        bus.in_x     = s.x[15:0];
        bus.in_y     = s.y[15:0];
        bus.in_z     = s.z[15:0];
    endtask

    function automatic samp_t mk(input bit m, input int x, input int y, input int z);
        samp_t s;
        s.m = m; s.x = x; s.y = y; s.z = z;
        return s;
    endfunction

    // Push one sample into an empty pipe and wait (bounded) for its result
    task automatic run_one(input samp_t s, output samp_t r, output int lat);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_in(1'b1, s);
        #1;
        check_eq("accept_ready", bus.in_ready, 1);
        @(negedge clk);
        drive_in(1'b0, mk(0, 0, 0, 0));
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r.m = bus.out_mode;
        r.x = int'(bus.out_x);
        r.y = int'(bus.out_y);
        r.z = int'(bus.out_z);
    endtask

    task automatic check_exact(input string tag, input samp_t got, input samp_t exp);
        check_eq({tag, "_x"}, got.x, exp.x);
        check_eq({tag, "_y"}, got.y, exp.y);
        check_eq({tag, "_z"}, got.z, exp.z);
        check_eq({tag, "_mode"}, got.m, exp.m);
    endtask

    initial begin
        samp_t s, r, e;
        samp_t stim [40];
        samp_t exp_q [$];
        int lat, sent, got, cyc, stale;
        bit prev_stall;
        samp_t prev;
        real ang, a;
        longint a32;

        ang = 1.0;
        for (int i = 0; i < STAGES; i++) begin
            a = $atan(ang) * 2147483648.0 / 3.141592653589793;
            a32 = longint'($floor(a + 0.5));
            atan_tb[i] = int'((a32 + 64'sd32768) >>> 16);
            ang = ang / 2.0;
        end

        bus.out_ready = 1'b0;
        drive_in(1'b0, mk(0, 0, 0, 0));
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_x", bus.out_x, 0);
        check_eq("rst_out_y", bus.out_y, 0);
        check_eq("rst_out_z", bus.out_z, 0);
        check_eq("rst_out_mode", bus.out_mode, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1);

        // Rotation by pi/4
        s = mk(0, 9949, 0, 8192);
        run_one(s, r, lat);
        check_eq("rot45_latency", lat, LAT);
        check_tol("rot45_x", r.x, 11585, 4);
        check_tol("rot45_y", r.y, 11585, 4);
        check_tol("rot45_z", r.z, 0, 2);
        check_exact("rot45_model", r, model(s));

        // Rotation by 3pi/4 through the pre-rotation stage
        s = mk(0, 9949, 0, 24576);
        run_one(s, r, lat);
        check_tol("rot135_x", r.x, -11585, 4);
        check_tol("rot135_y", r.y, 11585, 4);
        check_exact("rot135_model", r, model(s));

        // Vectoring in the first quadrant
        s = mk(1, 10000, 10000, 0);
        run_one(s, r, lat);
        check_tol("vec45_x", r.x, 23290, 8);
        check_tol("vec45_y", r.y, 0, 4);
        check_tol("vec45_z", r.z, 8192, 2);
        check_exact("vec45_model", r, model(s));

        // Vectoring with x<0
        s = mk(1, -10000, 10000, 0);
        run_one(s, r, lat);
        check_tol("vec135_z", r.z, 24576, 2);
        check_tol("vec135_x", r.x, 23290, 8);
        check_exact("vec135_model", r, model(s));

        // Back-to-back mixed-mode stream under random backpressure
        for (int k = 0; k < 40; k++) begin
            stim[k] = mk(k[0], int'($urandom_range(0, 40000)) - 20000,
                         int'($urandom_range(0, 40000)) - 20000,
                         int'($urandom_range(0, 65535)) - 32768);
        end
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0;
        prev = mk(0, 0, 0, 0);
        while (got < 40 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = (cyc >= 20 && cyc < 25) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (sent < 40) drive_in(1'b1, stim[sent]);
            else drive_in(1'b0, mk(0, 0, 0, 0));
            #1;
            check_eq("stream_in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (prev_stall) begin
                check_eq("stall_valid", bus.out_valid, 1);
                check_eq("stall_x", bus.out_x, prev.x);
                check_eq("stall_y", bus.out_y, prev.y);
                check_eq("stall_z", bus.out_z, prev.z);
                check_eq("stall_mode", bus.out_mode, prev.m);
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq($sformatf("stream%0d_present", got), exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    r.m = bus.out_mode; r.x = int'(bus.out_x);
                    r.y = int'(bus.out_y); r.z = int'(bus.out_z);
                    check_exact($sformatf("stream%0d", got), r, e);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(stim[sent]));
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev.m = bus.out_mode; prev.x = int'(bus.out_x);
            prev.y = int'(bus.out_y); prev.z = int'(bus.out_z);
        end
        check_eq("stream_count", got, 40);
        drive_in(1'b0, mk(0, 0, 0, 0));
        bus.out_ready = 1'b1;

        // Reset with ten samples in flight
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            drive_in(1'b1, stim[k]);
            @(negedge clk);
        end
        rst_n = 1'b0;
        drive_in(1'b1, mk(0, 5000, 0, 0));
        @(negedge clk);
        check_eq("midrst_valid", bus.out_valid, 0);
        check_eq("midrst_x", bus.out_x, 0);
        check_eq("midrst_y", bus.out_y, 0);
        check_eq("midrst_z", bus.out_z, 0);
        check_eq("midrst_mode", bus.out_mode, 0);
        rst_n = 1'b1;
        drive_in(1'b0, mk(0, 0, 0, 0));
        bus.out_ready = 1'b0;
        #1;
        check_eq("midrst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check_eq("midrst_no_stale", stale, 0);
        s = mk(1, 3000, -7000, 100);
        run_one(s, r, lat);
        check_eq("midrst_latency", lat, LAT);
        check_exact("midrst_model", r, model(s));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined CORDIC engine. It supports rotation and vectoring modes, selected per sample, and handles full-circle angles through a quadrant pre-rotation stage. It accepts one sample per cycle under a valid/ready handshake with global backpressure. It replaces the fixed 32-bit, 16-stage, rotation-only pipeline as the shared trig/magnitude primitive in the datapath.

## Interface
- W, default 16: width of the x/y/z inputs and z output; legal range 8–32.
- STAGES, default 16: number of CORDIC micro-rotations; legal range 4 to W.
- clk  in  1: rising-edge clock; the only clock.
- rst_n  in  1: synchronous, active-low reset.
- in_valid  in  1: input sample valid.
- in_ready  out  1: the block accepts the input this cycle.
- in_mode  in  1: 0 = rotation (drive z to 0); 1 = vectoring (drive y to 0).
- in_x, in_y  in  W: signed two's complement.
- in_z  in  W: signed binary angle, where +2^(W-1) maps to +π.
- out_valid  out  1: result valid.
- out_ready  in  1: the consumer accepts the result.
- out_mode  out  1: the mode travelling with the sample.
- out_x, out_y  out  W+2: signed; includes the uncompensated CORDIC gain.
- out_z  out  W: signed binary angle.

## Operation
- Transfer occurs on a cycle where valid and ready are both 1. Samples are never dropped, duplicated or reordered.
- advance = !out_valid || out_ready. in_ready = advance, which is combinational from out_ready and out_valid.
- Every pipeline register, including the valid and mode bits, loads only when advance=1. When advance=0 the whole pipe holds.
- Stage P (pre-rotation):
  - Rotation mode: if z ≥ +2^(W-2), rotate by +π/2: x'=-y, y'=x, z'=z-2^(W-2). If z < -2^(W-2), apply the mirror rotation. Otherwise pass through.
  - Vectoring mode: if x < 0, apply ±π/2 so that x' ≥ 0. Use y ≥ 0 to choose the direction, and add the same angle into z.
- x and y are sign-extended to W+2 bits at stage P. The 2 guard bits absorb the gain K ≈ 1.6468 plus the √2 growth, so no saturation logic is needed.
- Stage i, for i = 0..STAGES-1:
  - d = +1 if z ≥ 0 (rotation) or if y < 0 (vectoring); otherwise d = -1.
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·ATAN[i].
  - Shifts are arithmetic and truncating. All adds wrap modulo the stated width, so z wraps at ±π.
- No gain compensation is applied. The consumer scales by 1/K.
- ATAN[i] = round(atan(2^-i)·2^31/π) taken from the 32-bit package table, then right-shifted by (32-W) with round-half-up.

## Timing
- Latency is STAGES+2 accepted-advance cycles: 1 cycle for stage P, STAGES micro-rotation stages, and 1 output register. For W=16 and STAGES=16, the latency is 18 cycles.
- Throughput is 1 sample per cycle while out_ready=1.
- Reset values: out_valid=0, out_x=0, out_y=0, out_z=0, out_mode=0. All internal valid bits and data registers are 0. in_ready=1 in the first cycle after reset.
- Reset mid-stream: every in-flight sample is discarded. out_valid is 0 on the cycle after the rst_n=0 edge, and nothing emerges until new samples travel the full latency.
- Transfers presented while rst_n=0 are ignored.
- out_ready=0 with out_valid=1: outputs stay stable and in_ready=0.
- out_ready=0 with out_valid=0: the pipe keeps filling because bubbles are squeezed out at the output.
- Simultaneous input accept and output pop in the same cycle is the normal steady state; no bubble is inserted.
- Mixed modes back-to-back: the mode bit is carried per stage, and each stage uses its own sample's mode.

## Structure
- Package cordic_pkg holds:
  - ATAN32[0:31], the 32-bit binary-angle constants, e.g. ATAN32[0]=536870912 and ATAN32[1]=316933406.
  - The function atan_w(i, W) that applies the rounding shift.
  - The mode encoding constants MODE_ROT=0 and MODE_VEC=1.
- Sub-module cordic_stage, parametrised by W and index I: one micro-rotation plus its registers, with advance/valid/mode pass-through. It is instantiated through a generate loop, not by hand-instantiating stages.
- The top level contains stage P, the generate loop, the output register, and the handshake logic.

## Test plan
All scenarios use W=16 and STAGES=16.
- Rotation, in_x=9949, in_y=0, in_z=8192 (π/4) -> after 18 cycles out_x≈11585, out_y≈11585 (±4), out_z≈0 (±2).
- Rotation with pre-rotation, in_x=9949, in_y=0, in_z=24576 (3π/4) -> out_x≈-11585, out_y≈11585 (±4).
- Vectoring, in_x=10000, in_y=10000, in_z=0 -> out_x≈23290 (±8), out_y≈0 (±4), out_z≈8192 (±2).
- Vectoring with x<0, in_x=-10000, in_y=10000 -> out_z≈24576 (±2), out_x≈23290 (±8).
- Backpressure: 40 back-to-back samples with alternating modes, out_ready toggled randomly, including one 5-cycle low burst -> all 40 results arrive in order, each matching the reference model, and outputs are stable while stalled.
- Reset mid-stream: pull rst_n low for 1 cycle with 10 samples in flight -> out_valid=0 and all outputs are 0 on the next cycle, no stale results emerge, and a new sample appears exactly 18 cycles after it is accepted.
